// File: rtl/fp_pkg.sv
// Shared definitions for the sign/exponent/fraction float format: default field
// widths, exponent bias, packed layout and pack/unpack helpers.
package fp_pkg;

  localparam int FP_EXP_W  = 7;
  localparam int FP_FRAC_W = 16;
  localparam int FP_W      = 1 + FP_EXP_W + FP_FRAC_W;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_FRAC_W-1:0] frac;
  } fp_t;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic fp_t fp_unpack(input logic [FP_W-1:0] bits);
    return fp_t'(bits);
  endfunction

  function automatic logic [FP_W-1:0] fp_pack(input fp_t f);
    return f;
  endfunction

endpackage

// File: rtl/fp_mul_norm_round.sv
// Combinational normalise and round of a (1.f)*(1.f) mantissa product.
// FP_MUL_ROUND_NEAREST_EN selects round-to-nearest-even; otherwise truncation.
module fp_mul_norm_round #(
  parameter int FRAC_W = 16,
  parameter int XW     = 9
) (
  input  logic [2*FRAC_W+1:0]   mant_i,
  input  logic signed [XW-1:0]  exp_i,
  output logic [FRAC_W-1:0]     frac_o,
  output logic signed [XW-1:0]  exp_o
);

  localparam int PW = 2 * FRAC_W + 2;
`ifdef FP_MUL_ROUND_NEAREST_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic [PW-2:0]          norm;
  logic [FRAC_W-1:0]      frac_t;
  logic                   guard;
  logic                   sticky;
  logic                   round_up;
  logic                   carry;
  logic signed [XW-1:0]   exp_n;

  always_comb begin
    // Hidden bit is dropped here; the product is either 1x.xxx or 01.xxx
    norm     = mant_i[PW-1] ? mant_i[PW-2:0] : {mant_i[PW-3:0], 1'b0};
    exp_n    = exp_i + {{(XW-1){1'b0}}, mant_i[PW-1]};
    frac_t   = norm[PW-2 -: FRAC_W];
    guard    = norm[FRAC_W];
    sticky   = |norm[FRAC_W-1:0];
    round_up = RNE & guard & (sticky | frac_t[0]);
    {carry, frac_o} = {1'b0, frac_t} + {{FRAC_W{1'b0}}, round_up};
    exp_o    = exp_n + {{(XW-1){1'b0}}, carry};
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined float multiplier with valid/ready handshake and tag pass-through.
// Rounding mode selected by FP_MUL_ROUND_NEAREST_EN (undefined: truncation).
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W  = 7,
  parameter int FRAC_W = 16,
  parameter int TAG_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+FRAC_W:0]   float_a,
  input  logic [EXP_W+FRAC_W:0]   float_b,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   float_out,
  output logic [TAG_W-1:0]        out_tag,
  output logic                    float_out_underflow,
  output logic                    float_out_overflow
);

  localparam int W  = 1 + EXP_W + FRAC_W;
  localparam int PW = 2 * (FRAC_W + 1);
  localparam int XW = EXP_W + 2;
  localparam logic signed [XW-1:0] BIAS = XW'(fp_bias(EXP_W));

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } op_t;

  op_t a, b;
  assign a = op_t'(float_a);
  assign b = op_t'(float_b);

  logic advance;

  logic                  s1_valid_q, s1_sign_q, s1_zero_q;
  logic [PW-1:0]         s1_mant_q, s1_mant_d;
  logic signed [XW-1:0]  s1_exp_q, s1_exp_d;
  logic [TAG_W-1:0]      s1_tag_q;

  logic                  s2_valid_q, s2_sign_q, s2_zero_q;
  logic [FRAC_W-1:0]     s2_frac_q, s2_frac_d;
  logic signed [XW-1:0]  s2_exp_q, s2_exp_d;
  logic [TAG_W-1:0]      s2_tag_q;

  logic                  s3_valid_q, s3_uf_q, s3_of_q, s3_uf_d, s3_of_d;
  logic [W-1:0]          s3_res_q, s3_res_d;
  logic [TAG_W-1:0]      s3_tag_q;

  assign advance  = !s3_valid_q || out_ready;
  assign in_ready = advance;

  always_comb begin
    s1_mant_d = PW'({1'b1, a.frac}) * PW'({1'b1, b.frac});
    s1_exp_d  = $signed({2'b00, a.exp}) + $signed({2'b00, b.exp}) - BIAS;
  end

  fp_mul_norm_round #(
    .FRAC_W (FRAC_W),
    .XW     (XW)
  ) u_norm_round (
    .mant_i (s1_mant_q),
    .exp_i  (s1_exp_q),
    .frac_o (s2_frac_d),
    .exp_o  (s2_exp_d)
  );

  // In-range means 1 <= exp <= 2^EXP_W-1; bit EXP_W of a non-negative exp flags overflow
  always_comb begin
    s3_uf_d  = 1'b0;
    s3_of_d  = 1'b0;
    s3_res_d = {s2_sign_q, s2_exp_q[EXP_W-1:0], s2_frac_q};
    if (s2_zero_q) begin
      s3_res_d = {s2_sign_q, {(W-1){1'b0}}};
    end else if (!s2_exp_q[XW-1] && s2_exp_q[EXP_W]) begin
      s3_res_d = {s2_sign_q, {(W-1){1'b1}}};
      s3_of_d  = 1'b1;
    end else if (s2_exp_q[XW-1] || (s2_exp_q == '0)) begin
      s3_res_d = {s2_sign_q, {(W-1){1'b0}}};
      s3_uf_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_mant_q  <= '0;
      s1_exp_q   <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_zero_q  <= 1'b0;
      s2_frac_q  <= '0;
      s2_exp_q   <= '0;
      s2_tag_q   <= '0;
      s3_valid_q <= 1'b0;
      s3_uf_q    <= 1'b0;
      s3_of_q    <= 1'b0;
      s3_res_q   <= '0;
      s3_tag_q   <= '0;
    end else if (advance) begin
      s1_valid_q <= in_valid;
      s1_sign_q  <= a.sign ^ b.sign;
      s1_zero_q  <= (a.exp == '0) || (b.exp == '0);
      s1_mant_q  <= s1_mant_d;
      s1_exp_q   <= s1_exp_d;
      s1_tag_q   <= in_tag;
      s2_valid_q <= s1_valid_q;
      s2_sign_q  <= s1_sign_q;
      s2_zero_q  <= s1_zero_q;
      s2_frac_q  <= s2_frac_d;
      s2_exp_q   <= s2_exp_d;
      s2_tag_q   <= s1_tag_q;
      s3_valid_q <= s2_valid_q;
      s3_uf_q    <= s3_uf_d;
      s3_of_q    <= s3_of_d;
      s3_res_q   <= s3_res_d;
      s3_tag_q   <= s2_tag_q;
    end
  end

  assign out_valid           = s3_valid_q;
  assign float_out           = s3_res_q;
  assign out_tag             = s3_tag_q;
  assign float_out_underflow = s3_uf_q;
  assign float_out_overflow  = s3_of_q;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Self-checking bench for fp_mul_pipe: directed cases, stall/stream, mid-flight reset
// and randomized traffic against an arithmetic reference model.
module tb_fp_mul_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] float_a;
  logic [23:0] float_b;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] float_out;
  logic [3:0]  out_tag;
  logic        float_out_underflow;
  logic        float_out_overflow;

  always #5 clk = ~clk;

  fp_mul_pipe #(.EXP_W(7), .FRAC_W(16), .TAG_W(4)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .float_a             (float_a),
    .float_b             (float_b),
    .in_tag              (in_tag),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .float_out           (float_out),
    .out_tag             (out_tag),
    .float_out_underflow (float_out_underflow),
    .float_out_overflow  (float_out_overflow)
  );

  // expected word layout: {underflow, overflow, result[23:0]}
  typedef struct {
    logic [25:0] res;
    logic [3:0]  tag;
  } item_t;

  item_t       q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [25:0] cur_exp  = '0;
  logic        last_acc = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Real-number view: value = (1 + frac/2^16) * 2^(exp-63), scaled products handled as integers.
  function automatic logic [25:0] ref_mul(input logic [23:0] a, input logic [23:0] b);
    int     ea, eb, e;
    longint ma, mb, p, fr, rem, half;
    logic   s;
    logic [6:0]  eo;
    logic [15:0] fo;
    s  = a[23] ^ b[23];
    ea = int'(a[22:16]);
    eb = int'(b[22:16]);
    if (ea == 0 || eb == 0) return {2'b00, s, 23'd0};
    ma = longint'(a[15:0]) + 65536;
    mb = longint'(b[15:0]) + 65536;
    p  = ma * mb;
    e  = ea + eb - 63;
    if (p >= (longint'(1) << 33)) begin
      e    = e + 1;
      fr   = p / 131072;
      rem  = p % 131072;
      half = 65536;
    end else begin
      fr   = p / 65536;
      rem  = p % 65536;
      half = 32768;
    end
`ifdef FP_MUL_ROUND_NEAREST_EN
    if (rem > half || (rem == half && (fr % 2) == 1)) fr = fr + 1;
    if (fr == 131072) begin
      fr = 65536;
      e  = e + 1;
    end
`else
    if (rem < 0 || half < 0) fr = 0;
`endif
    if (e > 127) return {2'b01, s, 23'h7FFFFF};
    if (e < 1)   return {2'b10, s, 23'd0};
    eo = 7'(e);
    fo = 16'(fr % 65536);
    return {2'b00, s, eo, fo};
  endfunction

  // One clock: sample handshakes at negedge, return at posedge+1 for the next drive.
  task automatic tick();
    item_t it;
    @(negedge clk);
    last_acc = 1'b0;
    if (!rst) begin
      if (out_valid && out_ready) begin
        chk("spurious_output", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          it = q.pop_front();
          chk("result", 32'(float_out), 32'(it.res[23:0]));
          chk("tag", 32'(out_tag), 32'(it.tag));
          chk("flags", 32'({float_out_underflow, float_out_overflow}), 32'(it.res[25:24]));
        end
      end
      if (in_valid && in_ready) begin
        q.push_back('{res: cur_exp, tag: in_tag});
        last_acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [23:0] a, input logic [23:0] b, input logic [3:0] t,
                       input logic [25:0] e);
    in_valid = 1'b1;
    float_a  = a;
    float_b  = b;
    in_tag   = t;
    cur_exp  = e;
  endtask

  task automatic drive_rand(input logic [3:0] t);
    logic [23:0] a, b;
    a = 24'($urandom);
    b = 24'($urandom);
    if ($urandom_range(0, 9) == 0) a[22:16] = '0;
    if ($urandom_range(0, 3) == 0) begin
      a[22:16] = 7'($urandom_range(40, 90));
      b[22:16] = 7'($urandom_range(40, 90));
    end
    drive(a, b, t, ref_mul(a, b));
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 60 && q.size() != 0; i++) tick();
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    float_a   = '0;
    float_b   = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_float_out", 32'(float_out), 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_flags", 32'({float_out_underflow, float_out_overflow}), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Latency: 3.0 x 1.5 = 4.5
    drive(24'h408000, 24'h3F8000, 4'h1, {2'b00, 24'h412000});
    tick();
    in_valid = 1'b0;
    chk("lat_c1", 32'(out_valid), 32'd0);
    tick();
    chk("lat_c2", 32'(out_valid), 32'd0);
    tick();
    chk("lat_c3", 32'(out_valid), 32'd1);
    tick();

    // Directed back-to-back
    drive(24'hC00000, 24'h408000, 4'h2, {2'b00, 24'hC18000}); tick();
    drive(24'h000000, 24'hC08000, 4'h3, {2'b00, 24'h800000}); tick();
    drive(24'h7F0000, 24'h7F0000, 4'h4, {2'b01, 24'h7FFFFF}); tick();
    drive(24'h010000, 24'h010000, 4'h5, {2'b10, 24'h000000}); tick();
`ifdef FP_MUL_ROUND_NEAREST_EN
    drive(24'h3F8001, 24'h3F8000, 4'h6, {2'b00, 24'h402001}); tick();
`else
    drive(24'h3F8001, 24'h3F8000, 4'h6, {2'b00, 24'h402000}); tick();
`endif
    drain();

    // Stream of 8 with a 4-cycle downstream stall mid-stream
    for (int k = 0; k < 8; k++) begin
      drive_rand(4'(k));
      if (k == 4) begin
        out_ready = 1'b0;
        #1;
        for (int s = 0; s < 4; s++) begin
          chk("stall_in_ready", 32'(in_ready), 32'd0);
          chk("stall_out_valid", 32'(out_valid), 32'd1);
          chk("stall_hold", 32'(float_out), 32'(q[0].res[23:0]));
          tick();
        end
        out_ready = 1'b1;
      end
      tick();
    end
    drain();

    // Reset with three results in flight
    for (int k = 0; k < 3; k++) begin
      drive_rand(4'(8 + k));
      tick();
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    q.delete();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("midrst_no_stale", 32'(out_valid), 32'd0);
    end

    // Randomized traffic with random backpressure
    in_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!in_valid || last_acc) begin
        if ($urandom_range(0, 4) != 0) drive_rand(4'($urandom));
        else in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
